// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: column scanner with row synchroniser and press/release debounce for a 4x3 keypad
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [2:0] col_drive,
  output logic [3:0] R,
  output logic [2:0] C,
  output logic       press,
  output logic       held
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  state_t          state;
  logic [3:0]      rs1, rs, cand_row;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   cnt, rel;
  logic            tick, valid;
  logic [2:0]      col_next;
  assign tick     = timer == TW'(SCAN_DIV - 1);
  assign valid    = rs != 4'd0 && (rs & (rs - 4'd1)) == 4'd0;
  assign col_next = {col_drive[1:0], col_drive[2]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1       <= '0;
      rs        <= '0;
      cand_row  <= '0;
      timer     <= '0;
      cnt       <= '0;
      rel       <= '0;
      state     <= SCAN;
      col_drive <= 3'b001;
      R         <= '0;
      C         <= '0;
      press     <= 1'b0;
      held      <= 1'b0;
    end else begin
      rs1   <= row_in;
      rs    <= rs1;
      timer <= tick ? '0 : timer + 1'b1;
      press <= 1'b0;
      if (tick)
        case (state)
          SCAN:
            if (valid) begin
              cand_row <= rs;
              if (DEBOUNCE_CNT == 1) begin
                state <= PRESSED;
                R     <= rs;
                C     <= col_drive;
                press <= 1'b1;
                held  <= 1'b1;
              end else begin
                cnt   <= CW'(1);
                state <= DEBOUNCE;
              end
            end else
              col_drive <= col_next;
          DEBOUNCE:
            if (rs == cand_row) begin
              if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
                cnt   <= '0;
                state <= PRESSED;
                R     <= cand_row;
                C     <= col_drive;
                press <= 1'b1;
                held  <= 1'b1;
              end else
                cnt <= cnt + 1'b1;
            end else begin
              cnt       <= '0;
              col_drive <= col_next;
              state     <= SCAN;
            end
          PRESSED:
            // any non-empty sample, even another key, restarts the release count
            if (rs == 4'd0) begin
              if (rel == CW'(DEBOUNCE_CNT - 1)) begin
                rel       <= '0;
                R         <= '0;
                C         <= '0;
                held      <= 1'b0;
                col_drive <= col_next;
                state     <= SCAN;
              end else
                rel <= rel + 1'b1;
            end else
              rel <= '0;
          default: state <= SCAN;
        endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: directed keypad-model bench with a behavioural N/V decoder on R/C
module tb_keypad_scan_debounce;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [2:0] col_drive, C;
  logic [3:0] R;
  logic       press, held;
  logic [2:0] pressed [4];
  int tests = 0, failed = 0, press_cnt = 0, c0 = 0;
  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_drive(col_drive),
    .R(R), .C(C), .press(press), .held(held)
  );
  always #5 clk = ~clk;
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) row_in[r] = |(pressed[r] & col_drive);
  end
  always @(posedge clk) if (press) press_cnt <= press_cnt + 1;
  // phone layout: rows 1-2-3 / 4-5-6 / 7-8-9 / *(10)-0-#(11); -1 when R/C not one-hot
  function automatic int key_num(input logic [3:0] r, input logic [2:0] c);
    int ri = -1, ci = -1;
    for (int i = 0; i < 4; i++) if (r == 4'(1 << i)) ri = i;
    for (int i = 0; i < 3; i++) if (c == 3'(1 << i)) ci = i;
    if (ri < 0 || ci < 0) return -1;
    if (ri < 3) return ri * 3 + ci + 1;
    return ci == 0 ? 10 : ci == 1 ? 0 : 11;
  endfunction
  function automatic logic v_of(input logic [3:0] r, input logic [2:0] c);
    return key_num(r, c) >= 0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_press(input string tag, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = press;
    end
    check(tag, 32'(found), 32'd1);
  endtask
  task automatic wait_release(input string tag, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = !held;
    end
    check(tag, 32'(found), 32'd1);
  endtask
  task automatic wait_col(input string tag, input logic [2:0] t, input int budget);
    logic found = 1'b0;
    logic [2:0] prev = col_drive;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = col_drive == t && prev != t;
      prev = col_drive;
    end
    check(tag, 32'(found), 32'd1);
  endtask
  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = '0;
    #12;
    check("rst col", 32'(col_drive), 32'b001);
    check("rst R", 32'(R), 32'd0);
    check("rst C", 32'(C), 32'd0);
    check("rst press", 32'(press), 32'd0);
    check("rst held", 32'(held), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1 col0", 32'(col_drive), 32'b001);
    @(negedge clk);
    check("t1 col1", 32'(col_drive), 32'b010);
    repeat (4) @(negedge clk);
    check("t1 col2", 32'(col_drive), 32'b100);
    repeat (4) @(negedge clk);
    check("t1 col wrap", 32'(col_drive), 32'b001);
    check("t1 R", 32'(R), 32'd0);
    check("t1 V", 32'(v_of(R, C)), 32'd0);
    check("t1 no press", 32'(press_cnt), 32'd0);
    c0 = press_cnt;
    pressed[1][1] = 1'b1;
    wait_press("t2 press seen", 60);
    repeat (30) @(negedge clk);
    check("t2 one pulse", 32'(press_cnt - c0), 32'd1);
    check("t2 R", 32'(R), 32'b0010);
    check("t2 C", 32'(C), 32'b010);
    check("t2 held", 32'(held), 32'd1);
    check("t2 N", 32'(key_num(R, C)), 32'd5);
    check("t2 col frozen", 32'(col_drive), 32'b010);
    pressed[1][1] = 1'b0;
    wait_release("t4 release seen", 40);
    check("t4 R", 32'(R), 32'd0);
    check("t4 C", 32'(C), 32'd0);
    check("t4 V", 32'(v_of(R, C)), 32'd0);
    check("t4 col resumes", 32'(col_drive), 32'b100);
    c0 = press_cnt;
    pressed[1][1] = 1'b1;
    wait_press("t4 repress seen", 60);
    repeat (20) @(negedge clk);
    check("t4 repress one pulse", 32'(press_cnt - c0), 32'd1);
    pressed[1][1] = 1'b0;
    wait_release("t4 release2 seen", 40);
    c0 = press_cnt;
    wait_col("t3 find col0", 3'b001, 20);
    pressed[2][0] = 1'b1;
    repeat (4) @(negedge clk);
    check("t3 col held in debounce", 32'(col_drive), 32'b001);
    pressed[2][0] = 1'b0;
    repeat (4) @(negedge clk);
    check("t3 col resumes", 32'(col_drive), 32'b010);
    check("t3 R", 32'(R), 32'd0);
    check("t3 C", 32'(C), 32'd0);
    repeat (20) @(negedge clk);
    check("t3 no press", 32'(press_cnt - c0), 32'd0);
    c0 = press_cnt;
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    repeat (40) @(negedge clk);
    check("t5 two keys no press", 32'(press_cnt - c0), 32'd0);
    check("t5 held", 32'(held), 32'd0);
    wait_col("t5 scan continues", 3'b100, 20);
    pressed[0][0] = 1'b0;
    pressed[1][0] = 1'b0;
    c0 = press_cnt;
    pressed[3][2] = 1'b1;
    wait_press("t5 r3c2 press seen", 60);
    check("t5 R", 32'(R), 32'b1000);
    check("t5 C", 32'(C), 32'b100);
    check("t5 N", 32'(key_num(R, C)), 32'd11);
    pressed[3][2] = 1'b0;
    wait_release("t5 release seen", 40);
    pressed[2][0] = 1'b1;
    wait_press("t6 press seen", 60);
    @(negedge clk);
    check("t6 R before rst", 32'(R), 32'b0100);
    check("t6 C before rst", 32'(C), 32'b001);
    rst = 1'b1;
    #1;
    check("t6 R", 32'(R), 32'd0);
    check("t6 C", 32'(C), 32'd0);
    check("t6 held", 32'(held), 32'd0);
    check("t6 press", 32'(press), 32'd0);
    check("t6 col", 32'(col_drive), 32'b001);
    pressed[2][0] = 1'b0;
    @(negedge clk) rst = 1'b0;
    c0 = press_cnt;
    repeat (30) @(negedge clk);
    check("t6 no press on exit", 32'(press_cnt - c0), 32'd0);
    check("t6 held after exit", 32'(held), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
